weight_stream_bram: RTL

- Parametrised weight memory for one ANN neuron. Successor to the fixed 16x28 per-neuron weight BRAMs.
- Adds an internal read-address sequencer. One START streams all DEPTH weights in address order over a valid/ready interface, with full backpressure.
- Adds a guarded write/load port for updating weights.
- Sits between the weight store and the MAC datapath of each neuron.

---
 rtl/ann_pkg.sv | 16 +
 rtl/weight_skid_buf.sv | 62 ++++++
 rtl/weight_stream_bram.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ann_pkg.sv
// Shared constants and types for the ANN neuron datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default weight width, per-layer fan-in depths, weight-stream FSM encoding.
package ann_pkg;

   localparam int DATA_W_DEF = 16;   // default weight word width
   localparam int L0_DEPTH   = 28;   // layer-0 fan-in (weights per neuron)

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } ws_state_t;

endpackage

// File: rtl/weight_skid_buf.sv
// Two-entry valid/ready skid buffer between the weight BRAM read port and the consumer.
// Latency: 1 cycle from load to head_vld; sustains one word per cycle.
// Backpressure: no load-side ready; the producer must use 'count' so it never loads into a full buffer.
// Ports: clk/rst, load_vld/load_dat (BRAM read data), head_vld/head_dat/head_rdy (consumer side),
//        count (current occupancy 0..2).
module weight_skid_buf #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_vld,
   input  logic [W-1:0] load_dat,
   output logic         head_vld,
   output logic [W-1:0] head_dat,
   input  logic         head_rdy,
   output logic [1:0]   count
);

   logic         hv;
   logic [W-1:0] hd;
   logic         tv;
   logic [W-1:0] td;
   logic         pop;

   assign pop      = hv && head_rdy;
   assign head_vld = hv;
   assign head_dat = hd;
   assign count    = {1'b0, hv} + {1'b0, tv};

   // Head register drives the output directly, so it only changes on a pop
   // or when it is empty; that keeps the output stable while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hv <= 1'b0;
         hd <= '0;
         tv <= 1'b0;
         td <= '0;
      end else if (pop) begin
         if (tv) begin
            hd <= td;
            if (load_vld) begin
               td <= load_dat;
            end else begin
               tv <= 1'b0;
            end
         end else if (load_vld) begin
            hd <= load_dat;
         end else begin
            hv <= 1'b0;
         end
      end else if (load_vld) begin
         if (!hv) begin
            hd <= load_dat;
            hv <= 1'b1;
         end else begin
            td <= load_dat;
            tv <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/weight_stream_bram.sv
// Per-neuron weight memory that streams all DEPTH weights in address order after one START.
// Latency: START at edge 0 gives first DO_VALID at edge 2; DONE one cycle after the last handshake.
// Backpressure: full valid/ready on DO; reads stall (counter holds) while the 2-entry skid buffer is full.
// Ports: CLK, RST (async, active high); WR_EN/WR_ADDR/WR_DATA write port, WR_ERR reject pulse;
//        START, BUSY, DONE stream control; DO/DO_VALID/DO_READY/DO_LAST weight output.
module weight_stream_bram
   import ann_pkg::*;
#(
   parameter int    DATA_W    = DATA_W_DEF,
   parameter int    DEPTH     = L0_DEPTH,
   parameter int    ADDR_W    = 5,
   parameter string INIT_FILE = "weight.txt"
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              WR_EN,
   input  logic [ADDR_W-1:0] WR_ADDR,
   input  logic [DATA_W-1:0] WR_DATA,
   output logic              WR_ERR,
   input  logic              START,
   output logic              BUSY,
   output logic [DATA_W-1:0] DO,
   output logic              DO_VALID,
   input  logic              DO_READY,
   output logic              DO_LAST,
   output logic              DONE
);

   if (DEPTH < 2) begin : g_bad_depth
      $error("weight_stream_bram (%s): DEPTH must be at least 2", INIT_FILE);
   end
   if ((2 ** ADDR_W) < DEPTH) begin : g_bad_addr_w
      $error("weight_stream_bram (%s): ADDR_W too narrow for DEPTH", INIT_FILE);
   end

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   (* ram_style = "block" *) logic [DATA_W-1:0] mem [0:DEPTH-1];

   ws_state_t         state;
   ws_state_t         state_nxt;
   logic [ADDR_W-1:0] rd_addr;
   logic              issue;
   logic              done_nxt;
   logic              done_q;
   logic              wr_ok;
   logic              wr_err_q;
   logic              rd_vld;
   logic              rd_last;
   logic [DATA_W-1:0] rd_dat;
   logic              pop;
   logic [1:0]        skid_cnt;
   logic [2:0]        occ_after;
   logic              head_last;

   // Writes only land while idle, so they never collide with stream reads;
   // a write and START in the same cycle commits before the first read.
   assign wr_ok = WR_EN && (state == IDLE) && (WR_ADDR <= LAST_ADDR);
   assign pop   = DO_VALID && DO_READY;

   // Words held or in flight once this cycle's pop leaves; one more read
   // fits only if that is at most 1, so the skid buffer never overflows.
   assign occ_after = {1'b0, skid_cnt} + {2'b00, rd_vld} - {2'b00, pop};

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (START) begin
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            if (occ_after <= 3'd1) begin
               issue = 1'b1;
               if (rd_addr == LAST_ADDR) begin
                  state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pop && DO_LAST) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Read counter stops at the last address rather than wrapping.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_addr <= '0;
      end else if ((state == IDLE) && START) begin
         rd_addr <= '0;
      end else if (issue && (rd_addr != LAST_ADDR)) begin
         rd_addr <= rd_addr + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_vld   <= 1'b0;
         rd_last  <= 1'b0;
         done_q   <= 1'b0;
         wr_err_q <= 1'b0;
      end else begin
         rd_vld   <= issue;
         rd_last  <= issue && (rd_addr == LAST_ADDR);
         done_q   <= done_nxt;
         wr_err_q <= WR_EN && !wr_ok;
      end
   end

   // Memory array and its registered read port carry no reset.
   always_ff @(posedge CLK) begin
      if (wr_ok) begin
         mem[WR_ADDR] <= WR_DATA;
      end
      if (issue) begin
         rd_dat <= mem[rd_addr];
      end
   end

   weight_skid_buf #(
      .W (DATA_W + 1)
   ) u_skid (
      .clk      (CLK),
      .rst      (RST),
      .load_vld (rd_vld),
      .load_dat ({rd_last, rd_dat}),
      .head_vld (DO_VALID),
      .head_dat ({head_last, DO}),
      .head_rdy (DO_READY),
      .count    (skid_cnt)
   );

   // The head keeps its last payload after draining; gate the flag so it
   // never shows without a valid word.
   assign DO_LAST = head_last && DO_VALID;
   assign BUSY    = (state != IDLE);
   assign DONE    = done_q;
   assign WR_ERR  = wr_err_q;

endmodule
